// File: rtl/lvds_buf_pkg.sv
// Shared constants and reader state type for the 32x512 LVDS frame buffer.
package lvds_buf_pkg;

  localparam int BUF_AW    = 9;
  localparam int BUF_DW    = 32;
  localparam int BUF_WORDS = 512;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } rd_state_t;

endpackage

// File: rtl/lvds_rd_fifo.sv
// Show-ahead prefetch FIFO: rdata always reflects the head entry while not empty.
module lvds_rd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rd,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             wr_en;
  logic             rd_en;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == ($clog2(DEPTH+1))'(DEPTH));
  assign rd_en = rd && !empty;
  assign wr_en = wr && (!full || rd_en);
  assign rdata = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= next_ptr(wptr);
      if (rd_en) rptr <= next_ptr(rptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/lvds_frame_reader.sv
// Drains one frame from the LVDS frame buffer read port into a valid/ready
// stream, hiding the SRAM read latency behind a credit-controlled prefetch FIFO.
module lvds_frame_reader
  import lvds_buf_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = RD_LAT + 2
) (
  input  logic              RCLK,
  input  logic              RESET_N,
  input  logic              FRAME_RDY,
  input  logic [BUF_AW-1:0] START_ADDR,
  input  logic [9:0]        FRAME_LEN,
  output logic [BUF_AW-1:0] RADDR,
  input  logic [BUF_DW-1:0] RD,
  output logic [BUF_DW-1:0] DOUT,
  output logic              DVALID,
  input  logic              DREADY,
  output logic              DLAST,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVERRUN
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  rd_state_t         state;
  logic [9:0]        remaining;
  logic [9:0]        eff_len;
  logic [RD_LAT-1:0] vld_sr;
  logic [RD_LAT-1:0] last_sr;
  logic              issue;
  logic              issue_last;
  logic              pop;
  logic [7:0]        level;
  logic              fifo_wr;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [BUF_DW:0]   head;

  assign eff_len = (FRAME_LEN > 10'(BUF_WORDS)) ? 10'(BUF_WORDS) : FRAME_LEN;
  assign pop     = DVALID && DREADY;

  // Credit: words queued plus words still in the SRAM pipe must fit the FIFO,
  // counting this cycle's pop so full throughput needs no bubble.
  assign level      = 8'(fifo_count) + 8'($countones(vld_sr)) - {7'd0, pop};
  assign issue      = (state == READ) && (level < 8'(FIFO_DEPTH));
  assign issue_last = issue && (remaining == 10'd1);

  always_ff @(posedge RCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else begin
      vld_sr[0]  <= issue;
      last_sr[0] <= issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  always_ff @(posedge RCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      RADDR     <= '0;
      remaining <= '0;
      DONE      <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      DONE    <= 1'b0;
      OVERRUN <= FRAME_RDY && (state != IDLE);
      case (state)
        IDLE: begin
          if (FRAME_RDY && (eff_len != 10'd0)) begin
            RADDR     <= START_ADDR;
            remaining <= eff_len;
            state     <= READ;
          end
        end
        READ: begin
          if (issue) begin
            RADDR     <= RADDR + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == 10'd1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && DLAST) begin
            state <= IDLE;
            DONE  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fifo_wr = vld_sr[RD_LAT-1] && (!fifo_full || pop);

  lvds_rd_fifo #(
    .WIDTH(BUF_DW + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (RCLK),
    .rst_n(RESET_N),
    .wr   (fifo_wr),
    .wdata({last_sr[RD_LAT-1], RD}),
    .rd   (pop),
    .rdata(head),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign DVALID = !fifo_empty;
  assign DOUT   = fifo_empty ? '0 : head[BUF_DW-1:0];
  assign DLAST  = !fifo_empty && head[BUF_DW];
  assign BUSY   = (state != IDLE);

endmodule

// File: tb/tb_lvds_frame_reader.sv
// Scoreboard bench for lvds_frame_reader: stimulus queues expected words, a monitor checks the stream.
module tb_lvds_frame_reader;

  localparam int RD_LAT     = 1;
  localparam int FIFO_DEPTH = RD_LAT + 2;

  logic        RCLK       = 1'b0;
  logic        RESET_N    = 1'b0;
  logic        FRAME_RDY  = 1'b0;
  logic [8:0]  START_ADDR = '0;
  logic [9:0]  FRAME_LEN  = '0;
  logic [8:0]  RADDR;
  logic [31:0] RD         = '0;
  logic [31:0] DOUT;
  logic        DVALID;
  logic        DREADY     = 1'b1;
  logic        DLAST;
  logic        BUSY;
  logic        DONE;
  logic        OVERRUN;

  int          n_checks    = 0;
  int          n_fail      = 0;
  int          cyc         = 0;
  int          t0          = 0;
  int          frame_hs    = 0;
  int          first_hs_cyc = 0;
  int          last_hs_cyc = 0;
  int          done_count  = 0;
  int          done_cyc    = 0;
  int          ovr_cycles  = 0;
  bit          bp_mode     = 1'b0;
  logic        prev_stall  = 1'b0;
  logic [31:0] prev_dout   = '0;
  logic [32:0] exp_q[$];

  lvds_frame_reader #(
    .RD_LAT    (RD_LAT),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .RCLK      (RCLK),
    .RESET_N   (RESET_N),
    .FRAME_RDY (FRAME_RDY),
    .START_ADDR(START_ADDR),
    .FRAME_LEN (FRAME_LEN),
    .RADDR     (RADDR),
    .RD        (RD),
    .DOUT      (DOUT),
    .DVALID    (DVALID),
    .DREADY    (DREADY),
    .DLAST     (DLAST),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .OVERRUN   (OVERRUN)
  );

  function automatic logic [31:0] ramWord(input logic [8:0] a);
    return {8'hA5, 7'h00, a, 8'h3C};
  endfunction

  initial forever #5 RCLK = ~RCLK;

  initial forever begin
    @(posedge RCLK);
    cyc++;
  end

  // Buffer model with a one-cycle read latency.
  always @(posedge RCLK) RD <= ramWord(RADDR);

  initial forever begin
    @(posedge RCLK);
    #1;
    DREADY = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold-while-stalled.
  initial forever begin
    @(negedge RCLK);
    if (RESET_N) begin
      if (prev_stall) begin
        checkOutput("dvalid_hold", 64'(DVALID), 64'd1);
        checkOutput("dout_hold", 64'(DOUT), 64'(prev_dout));
      end
      if (DVALID && DREADY) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL extra_word: got 0x%0h, expected no word", DOUT);
        end else begin
          checkOutput("stream_word", 64'({DLAST, DOUT}), 64'(exp_q.pop_front()));
        end
        if (frame_hs == 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        frame_hs++;
      end
      if (DONE) begin
        done_count++;
        done_cyc = cyc;
      end
      if (OVERRUN) ovr_cycles++;
      prev_stall = DVALID && !DREADY;
      prev_dout  = DOUT;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic pulseFrameRdy(input logic [8:0] start, input logic [9:0] len);
    @(posedge RCLK);
    #1;
    FRAME_RDY  = 1'b1;
    START_ADDR = start;
    FRAME_LEN  = len;
    @(posedge RCLK);
    #1;
    t0         = cyc;
    FRAME_RDY  = 1'b0;
    START_ADDR = 9'($urandom);
    FRAME_LEN  = 10'($urandom);
  endtask

  task automatic applyStimulus(input logic [8:0] start, input logic [9:0] len, input bit expect_accept);
    int eff;
    eff = (len > 10'd512) ? 512 : int'(len);
    frame_hs = 0;
    if (expect_accept) begin
      for (int i = 0; i < eff; i++) exp_q.push_back({i == eff - 1, ramWord(9'(int'(start) + i))});
    end
    pulseFrameRdy(start, len);
  endtask

  task automatic waitDone(input int bound);
    int start_cnt;
    start_cnt = done_count;
    for (int i = 0; i < bound; i++) begin
      @(negedge RCLK);
      #1;
      if (done_count != start_cnt) break;
    end
    checkOutput("done_pulse", 64'(done_count - start_cnt), 64'd1);
    checkOutput("busy_at_done", 64'(BUSY), 64'd0);
    @(negedge RCLK);
    #1;
    checkOutput("done_width", 64'(DONE), 64'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_raddr"}, 64'(RADDR), 64'd0);
    checkOutput({tag, "_dout"}, 64'(DOUT), 64'd0);
    checkOutput({tag, "_dvalid"}, 64'(DVALID), 64'd0);
    checkOutput({tag, "_dlast"}, 64'(DLAST), 64'd0);
    checkOutput({tag, "_busy"}, 64'(BUSY), 64'd0);
    checkOutput({tag, "_done"}, 64'(DONE), 64'd0);
    checkOutput({tag, "_overrun"}, 64'(OVERRUN), 64'd0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    int o0;
    repeat (3) @(posedge RCLK);
    #1;
    checkResetValues("reset");
    RESET_N = 1'b1;
    repeat (2) @(posedge RCLK);

    $display("[TB] single 16-word frame");
    applyStimulus(9'h000, 10'd16, 1'b1);
    checkOutput("busy_c1", 64'(BUSY), 64'd1);
    checkOutput("raddr_c1", 64'(RADDR), 64'd0);
    waitDone(40);
    checkOutput("first_word_cycle", 64'(first_hs_cyc - t0 + 1), 64'd3);
    checkOutput("last_word_cycle", 64'(last_hs_cyc - t0 + 1), 64'd18);
    checkOutput("done_cycle", 64'(done_cyc - t0 + 1), 64'd19);
    checkOutput("single_count", 64'(frame_hs), 64'd16);

    $display("[TB] wrap-around frame");
    applyStimulus(9'h1FC, 10'd8, 1'b1);
    checkOutput("wrap_raddr_c1", 64'(RADDR), 64'h1FC);
    waitDone(40);
    checkOutput("wrap_count", 64'(frame_hs), 64'd8);
    checkOutput("wrap_raddr_end", 64'(RADDR), 64'h004);

    $display("[TB] backpressure frame");
    bp_mode = 1'b1;
    applyStimulus(9'h040, 10'd32, 1'b1);
    waitDone(600);
    bp_mode = 1'b0;
    checkOutput("bp_count", 64'(frame_hs), 64'd32);
    checkOutput("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] length boundaries");
    d0 = done_count;
    applyStimulus(9'h010, 10'd0, 1'b0);
    checkOutput("len0_busy", 64'(BUSY), 64'd0);
    repeat (5) @(negedge RCLK);
    #1;
    checkOutput("len0_done", 64'(done_count - d0), 64'd0);
    checkOutput("len0_dvalid", 64'(DVALID), 64'd0);
    applyStimulus(9'h100, 10'd1, 1'b1);
    waitDone(20);
    checkOutput("len1_count", 64'(frame_hs), 64'd1);
    applyStimulus(9'h000, 10'd600, 1'b1);
    waitDone(600);
    checkOutput("len600_count", 64'(frame_hs), 64'd512);
    checkOutput("len600_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] overrun");
    o0 = ovr_cycles;
    applyStimulus(9'h080, 10'd64, 1'b1);
    repeat (10) @(posedge RCLK);
    pulseFrameRdy(9'h1F0, 10'd5);
    waitDone(200);
    checkOutput("overrun_cycles", 64'(ovr_cycles - o0), 64'd1);
    checkOutput("overrun_count", 64'(frame_hs), 64'd64);
    repeat (5) @(negedge RCLK);
    #1;
    checkOutput("overrun_no_second_busy", 64'(BUSY), 64'd0);
    checkOutput("overrun_no_second_valid", 64'(DVALID), 64'd0);

    $display("[TB] reset mid-frame");
    applyStimulus(9'h000, 10'd40, 1'b1);
    for (int i = 0; i < 100 && frame_hs < 10; i++) begin
      @(negedge RCLK);
      #1;
    end
    checkOutput("reset_reached_word10", 64'(frame_hs), 64'd10);
    #2;
    RESET_N = 1'b0;
    #1;
    checkResetValues("async_reset");
    exp_q.delete();
    repeat (3) @(posedge RCLK);
    #1;
    RESET_N = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge RCLK);
      checkOutput("dvalid_post_reset", 64'(DVALID), 64'd0);
    end
    checkOutput("busy_post_reset", 64'(BUSY), 64'd0);
    applyStimulus(9'h020, 10'd4, 1'b1);
    checkOutput("post_reset_raddr_c1", 64'(RADDR), 64'h020);
    waitDone(30);
    checkOutput("post_reset_count", 64'(frame_hs), 64'd4);

    checkOutput("queue_empty_end", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lvds_frame_reader.md
# lvds_frame_reader

Read-side controller for the 32x512 two-port LVDS frame buffer. The LVDS receiver writes a frame into the buffer through the write port. This block then drains the frame through the read port (RADDR/RD) and presents it as a 32-bit valid/ready stream with a last-word marker. It accounts for the fixed SRAM read latency and absorbs downstream backpressure without losing or duplicating words.

## Interface
Parameters:
- RD_LAT, 1, SRAM read latency in RCLK cycles, from RADDR presented to RD valid (legal values 1..2)
- FIFO_DEPTH, RD_LAT+2, depth of the prefetch FIFO; sized for one word per cycle at full throughput

Ports:
- RCLK  in  1  single clock; read-port clock of the buffer
- RESET_N  in  1  reset, asynchronous, active-low
- FRAME_RDY  in  1  one-cycle pulse: a complete frame is in the buffer (already in the RCLK domain)
- START_ADDR  in  9  first buffer address of the frame; sampled on FRAME_RDY
- FRAME_LEN  in  10  frame length in words; sampled on FRAME_RDY
- RADDR  out  9  buffer read address
- RD  in  32  buffer read data, valid RD_LAT cycles after RADDR
- DOUT  out  32  stream data
- DVALID  out  1  stream valid
- DREADY  in  1  stream ready
- DLAST  out  1  qualifies the final word of the frame
- BUSY  out  1  a frame is being read or drained
- DONE  out  1  one-cycle pulse after the last word handshakes
- OVERRUN  out  1  one-cycle pulse: FRAME_RDY arrived while BUSY was high

## Operation
- FSM states:
  - IDLE: waits for a frame.
  - READ: issues buffer reads.
  - DRAIN: all reads issued; waits for the FIFO to empty.
- IDLE -> READ:
  - Triggered by FRAME_RDY with a non-zero effective length.
  - Effective length is FRAME_LEN, clamped to 512 when FRAME_LEN > 512.
  - FRAME_LEN = 0 is ignored: the FSM stays in IDLE and no DONE is produced.
- READ:
  - One read is issued per cycle while (FIFO occupancy + reads in flight − pop this cycle) < FIFO_DEPTH.
  - After each issued read, RADDR increments modulo 512; 511 wraps to 0.
  - The remaining-word counter decrements once per issued read.
  - READ -> DRAIN on the cycle the last read is issued.
- Data path:
  - The RD_LAT-deep valid shift register marks in-flight reads.
  - RD is written into the FIFO when the shift register's tail bit is set.
  - The FIFO is show-ahead: DOUT/DVALID reflect the FIFO head.
  - A pop occurs on DVALID & DREADY.
- DLAST:
  - The FIFO carries a last tag bit alongside each word.
  - The tag is set on the word from the final issued read.
- DRAIN -> IDLE:
  - Happens on the handshake of the DLAST word.
  - DONE pulses in the following cycle; BUSY drops in the same cycle as DONE.
- FRAME_RDY while BUSY: the request is dropped, OVERRUN pulses, and the current frame is unaffected.
- DVALID stability: once asserted, DVALID holds and DOUT is stable until the handshake.
- Reset:
  - Reset mid-frame aborts immediately.
  - The FIFO and in-flight state are flushed; no partial stream continues after reset release.
- Reset values: RADDR=0, DOUT=0, DVALID=0, DLAST=0, BUSY=0, DONE=0, OVERRUN=0, FSM=IDLE.

## Timing
- FRAME_RDY sampled at edge 0:
  - BUSY=1 and RADDR=START_ADDR from cycle 1 (first read issued in cycle 1).
  - First DVALID in cycle 2+RD_LAT, i.e. cycle 3 for RD_LAT=1.
- Throughput with DREADY held high: one word per cycle, no bubbles. An N-word frame ends with the DLAST handshake in cycle N+1+RD_LAT.
- Backpressure:
  - While DREADY is low, reads stall within FIFO_DEPTH.
  - After DREADY rises, the first handshake happens in the same cycle; there is no added latency.
- DONE: cycle after the DLAST handshake; a new FRAME_RDY is accepted from that cycle onward.
- Ports sampled only on FRAME_RDY: START_ADDR and FRAME_LEN. Changes at other times have no effect.

## Structure
- Package lvds_buf_pkg holds:
  - constants: BUF_AW=9, BUF_DW=32, BUF_WORDS=512
  - reader state enum {IDLE, READ, DRAIN}
- Sub-module lvds_rd_fifo:
  - synchronous show-ahead FIFO, parameterised on width (33 = data + last tag) and depth
  - outputs count, full, empty
- The top level holds the FSM, address/remaining counters, in-flight shift register and credit logic.

## Test plan
- Single frame: START_ADDR=0x000, FRAME_LEN=16, DREADY=1, RD_LAT=1. Response:
  - 16 words in consecutive cycles 3..18, matching RAM contents
  - DLAST on word 16
  - DONE pulse in cycle 19
- Wrap-around: START_ADDR=0x1FC, FRAME_LEN=8. Response:
  - RADDR sequence 0x1FC..0x1FF, 0x000..0x003
  - data in that order; DLAST on the 8th word
- Backpressure: FRAME_LEN=32, DREADY toggling pseudo-randomly 50%. Response:
  - all 32 words delivered in order, with no duplicates or losses
  - DOUT stable while DVALID & !DREADY
  - in-flight + occupancy never exceeds FIFO_DEPTH
- Length boundaries:
  - FRAME_LEN=0: no BUSY, no DONE.
  - FRAME_LEN=1: a single word with DLAST=1.
  - FRAME_LEN=600: exactly 512 words delivered.
- Overrun: a second FRAME_RDY during a 64-word frame. Response:
  - OVERRUN pulses for one cycle
  - the first frame completes intact; no second frame starts
- Reset mid-frame: assert RESET_N=0 at word 10 of 40. Response:
  - all outputs at reset values asynchronously
  - after release, DVALID stays 0 until the next FRAME_RDY
  - the next 4-word frame at START_ADDR=0x020 streams correctly
